// File: rtl/multi_digi.sv
// multi_digi: multi-channel trigger-capture digitizer.
//
// NCH ADC channels are written in lockstep into per-channel circular buffers
// of depth 2**SIZE. On TRIGGER the block keeps up to 'offset' pre-trigger
// samples and captures the remaining post-trigger samples. It then serialises
// 'howmany' words per enabled channel through a one-word-per-request pull port.
//
// Ports:
//   CK50        clock, rising edge
//   RST         asynchronous active-high reset
//   DAVAIL      sample strobe common to all channels
//   adcdata     channel k sample at [k*WIDTH +: WIDTH]
//   TRIGGER     level trigger, sampled every cycle
//   ch_mask     channels included in readout (latched at trigger)
//   howmany     samples read per channel (latched at trigger)
//   offset      pre-trigger samples (latched at trigger, clamped to howmany)
//   rd_request  host pulls one word per high cycle during readout
//   dout        readout sample, registered
//   dout_valid  dout/dout_ch valid this cycle
//   dout_ch     channel index of dout
//   busy        high while capturing, reading out or finishing
//   ro_done     one-cycle pulse coinciding with the final dout_valid
//   trig_lost   sticky flag: trigger arrived while busy
module multi_digi #(
  parameter int NCH   = 4,
  parameter int SIZE  = 8,
  parameter int WIDTH = 16,
  parameter int CHW   = 2
) (
  input  logic                 CK50,
  input  logic                 RST,
  input  logic                 DAVAIL,
  input  logic [NCH*WIDTH-1:0] adcdata,
  input  logic                 TRIGGER,
  input  logic [NCH-1:0]       ch_mask,
  input  logic [SIZE-1:0]      howmany,
  input  logic [SIZE-1:0]      offset,
  input  logic                 rd_request,
  output logic [WIDTH-1:0]     dout,
  output logic                 dout_valid,
  output logic [CHW-1:0]       dout_ch,
  output logic                 busy,
  output logic                 ro_done,
  output logic                 trig_lost
);

  typedef enum logic [1:0] {S_IDLE, S_POST, S_READOUT, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [SIZE-1:0] wp_q, wp_d;
  logic [SIZE-1:0] start_q, start_d;
  logic [SIZE-1:0] post_q, post_d;
  logic [SIZE-1:0] hm_q, hm_d;
  logic [SIZE-1:0] rd_q, rd_d;
  logic [SIZE-1:0] cnt_q, cnt_d;
  logic [NCH-1:0]  mask_q, mask_d;
  logic [CHW-1:0]  ch_q, ch_d;
  logic [CHW-1:0]  dout_ch_q, dout_ch_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic            dout_valid_q, dout_valid_d;
  logic            trig_lost_q, trig_lost_d;

  logic            wr_en;
  logic            go_readout;
  logic [SIZE-1:0] pre, post_init;
  logic [CHW:0]    nc;

  logic [WIDTH-1:0] mem [NCH][2**SIZE];

  // Lowest set mask bit strictly above 'above' (-1 = search from bit 0).
  // Returns {found, index}.
  function automatic logic [CHW:0] next_ch(input logic [NCH-1:0] m, input int above);
    logic [CHW:0] r;
    r = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      if (m[k] && (k > above)) r = {1'b1, CHW'(k)};
    end
    return r;
  endfunction

  always_comb begin
    state_d      = state_q;
    wp_d         = wp_q;
    start_d      = start_q;
    post_d       = post_q;
    hm_d         = hm_q;
    rd_d         = rd_q;
    cnt_d        = cnt_q;
    mask_d       = mask_q;
    ch_d         = ch_q;
    dout_ch_d    = dout_ch_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    trig_lost_d  = trig_lost_q;
    go_readout   = 1'b0;
    nc           = '0;

    pre       = (offset < howmany) ? offset : howmany;
    post_init = howmany - pre;

    // Writes happen only while the buffer is still collecting samples.
    wr_en = DAVAIL && ((state_q == S_IDLE) || (state_q == S_POST));
    if (wr_en) wp_d = wp_q + SIZE'(1);

    if (TRIGGER && (state_q != S_IDLE)) trig_lost_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (TRIGGER) begin
          mask_d  = ch_mask;
          hm_d    = howmany;
          start_d = wp_q - pre;
          // A sample written in the trigger cycle is the first post sample.
          if (post_init == '0) begin
            go_readout = 1'b1;
          end else if (DAVAIL && (post_init == SIZE'(1))) begin
            go_readout = 1'b1;
          end else begin
            state_d = S_POST;
            post_d  = DAVAIL ? (post_init - SIZE'(1)) : post_init;
          end
        end
      end
      S_POST: begin
        if (DAVAIL) begin
          post_d = post_q - SIZE'(1);
          if (post_q == SIZE'(1)) go_readout = 1'b1;
        end
      end
      S_READOUT: begin
        if (rd_request) begin
          dout_d       = mem[ch_q][rd_q];
          dout_ch_d    = ch_q;
          dout_valid_d = 1'b1;
          rd_d         = rd_q + SIZE'(1);
          cnt_d        = cnt_q + SIZE'(1);
          if (cnt_q == (hm_q - SIZE'(1))) begin
            nc = next_ch(mask_q, int'(ch_q));
            if (nc[CHW]) begin
              ch_d  = nc[CHW-1:0];
              rd_d  = start_q;
              cnt_d = '0;
            end else begin
              state_d = S_DONE;
            end
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Entering readout: start at the lowest enabled channel, or finish at
    // once when there is nothing to read.
    if (go_readout) begin
      nc = next_ch(mask_d, -1);
      if (!nc[CHW] || (hm_d == '0)) begin
        state_d = S_DONE;
      end else begin
        state_d = S_READOUT;
        ch_d    = nc[CHW-1:0];
        rd_d    = start_d;
        cnt_d   = '0;
      end
    end
  end

  always_ff @(posedge CK50 or posedge RST) begin
    if (RST) begin
      state_q      <= S_IDLE;
      wp_q         <= '0;
      start_q      <= '0;
      post_q       <= '0;
      hm_q         <= '0;
      rd_q         <= '0;
      cnt_q        <= '0;
      mask_q       <= '0;
      ch_q         <= '0;
      dout_ch_q    <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      trig_lost_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      wp_q         <= wp_d;
      start_q      <= start_d;
      post_q       <= post_d;
      hm_q         <= hm_d;
      rd_q         <= rd_d;
      cnt_q        <= cnt_d;
      mask_q       <= mask_d;
      ch_q         <= ch_d;
      dout_ch_q    <= dout_ch_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      trig_lost_q  <= trig_lost_d;
    end
  end

  // Sample buffers are deliberately not reset.
  always_ff @(posedge CK50) begin
    if (wr_en) begin
      for (int k = 0; k < NCH; k++) begin
        mem[k][wp_q] <= adcdata[k*WIDTH +: WIDTH];
      end
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign dout_ch    = dout_ch_q;
  assign busy       = (state_q != S_IDLE);
  assign ro_done    = (state_q == S_DONE);
  assign trig_lost  = trig_lost_q;

endmodule

// File: tb/tb_multi_digi.sv
// tb_multi_digi: scoreboard bench for multi_digi.
// Stimulus tasks push expected readout words into a queue; an independent
// monitor pops and compares whenever the DUT presents dout_valid or ro_done.
module tb_multi_digi;

  localparam int NCH   = 4;
  localparam int SIZE  = 8;
  localparam int WIDTH = 16;
  localparam int CHW   = 2;

  logic                 CK50 = 1'b0;
  logic                 RST;
  logic                 DAVAIL;
  logic [NCH*WIDTH-1:0] adcdata;
  logic                 TRIGGER;
  logic [NCH-1:0]       ch_mask;
  logic [SIZE-1:0]      howmany;
  logic [SIZE-1:0]      offset;
  logic                 rd_request;
  logic [WIDTH-1:0]     dout;
  logic                 dout_valid;
  logic [CHW-1:0]       dout_ch;
  logic                 busy;
  logic                 ro_done;
  logic                 trig_lost;

  multi_digi #(.NCH(NCH), .SIZE(SIZE), .WIDTH(WIDTH), .CHW(CHW)) dut (
    .CK50(CK50), .RST(RST), .DAVAIL(DAVAIL), .adcdata(adcdata),
    .TRIGGER(TRIGGER), .ch_mask(ch_mask), .howmany(howmany), .offset(offset),
    .rd_request(rd_request), .dout(dout), .dout_valid(dout_valid),
    .dout_ch(dout_ch), .busy(busy), .ro_done(ro_done), .trig_lost(trig_lost)
  );

  always #5 CK50 = ~CK50;

  typedef struct {
    logic [WIDTH-1:0] data;
    logic [CHW-1:0]   ch;
    logic             last;
  } exp_t;

  exp_t            exp_q[$];
  int              checks = 0;
  int              passed = 0;
  int              empty_done = 0;
  logic [3:0]      epoch = '0;
  logic [SIZE-1:0] tb_wp = '0;
  logic [WIDTH-1:0] model_mem [NCH][2**SIZE];
  logic [SIZE-1:0] st;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passed++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
  endtask

  // Sample value encodes epoch, channel and write address.
  function automatic logic [WIDTH-1:0] sample_val(input int k);
    logic [1:0] kk;
    kk = k[1:0];
    return {epoch, 2'b00, kk, tb_wp};
  endfunction

  task automatic drive_and_record();
    for (int k = 0; k < NCH; k++) begin
      adcdata[k*WIDTH +: WIDTH] = sample_val(k);
      model_mem[k][tb_wp] = sample_val(k);
    end
    tb_wp = tb_wp + SIZE'(1);
  endtask

  task automatic write_samples(input int n);
    for (int i = 0; i < n; i++) begin
      drive_and_record();
      DAVAIL = 1'b1;
      @(posedge CK50);
      #1;
      DAVAIL = 1'b0;
    end
  endtask

  task automatic do_trigger(input logic [NCH-1:0] m, input logic [SIZE-1:0] hm,
                            input logic [SIZE-1:0] off, input logic dav,
                            output logic [SIZE-1:0] start);
    logic [SIZE-1:0] p;
    p = (off < hm) ? off : hm;
    start = tb_wp - p;
    ch_mask = m;
    howmany = hm;
    offset = off;
    TRIGGER = 1'b1;
    if (dav) begin
      drive_and_record();
      DAVAIL = 1'b1;
    end
    @(posedge CK50);
    #1;
    TRIGGER = 1'b0;
    DAVAIL = 1'b0;
  endtask

  task automatic push_words(input logic [NCH-1:0] m, input logic [SIZE-1:0] start,
                            input int hm);
    int top;
    logic [SIZE-1:0] a;
    top = -1;
    for (int k = 0; k < NCH; k++) if (m[k]) top = k;
    for (int k = 0; k < NCH; k++) begin
      if (m[k]) begin
        for (int i = 0; i < hm; i++) begin
          a = start + SIZE'(i);
          exp_q.push_back('{data: model_mem[k][a], ch: CHW'(k),
                            last: (k == top) && (i == hm - 1)});
        end
      end
    end
  endtask

  task automatic read_n(input int n);
    rd_request = 1'b1;
    repeat (n) @(posedge CK50);
    #1;
    rd_request = 1'b0;
  endtask

  // Last word must appear right after the final request, then the DUT idles.
  task automatic finish_readout(input string name);
    @(negedge CK50);
    #1;
    check({name, "_drained"}, exp_q.size() + empty_done, 0);
    @(posedge CK50);
    #1;
    check({name, "_idle"}, busy, 0);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    DAVAIL = 1'b0;
    TRIGGER = 1'b0;
    rd_request = 1'b0;
    adcdata = '0;
    ch_mask = '0;
    howmany = '0;
    offset = '0;
    repeat (2) @(posedge CK50);
    @(negedge CK50);
    check("rst_dout", dout, 0);
    check("rst_dout_valid", dout_valid, 0);
    check("rst_dout_ch", dout_ch, 0);
    check("rst_busy", busy, 0);
    check("rst_ro_done", ro_done, 0);
    check("rst_trig_lost", trig_lost, 0);
    @(posedge CK50);
    #1;
    RST = 1'b0;
    tb_wp = '0;
  endtask

  // Monitor: compares every presented word or empty ro_done pulse.
  initial begin
    exp_t e;
    forever begin
      @(negedge CK50);
      if (!RST) begin
        if (dout_valid) begin
          check("word_expected", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("dout", dout, e.data);
            check("dout_ch", dout_ch, e.ch);
            check("ro_done_align", ro_done, e.last);
          end
        end else if (ro_done) begin
          check("ro_done_nodata", empty_done > 0, 1);
          if (empty_done > 0) empty_done--;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation timed out, expected completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    RST = 1'b1;
    do_reset();

    // Basic capture: ramp 0..9, trigger at wp=10 with sample, 4 more samples.
    epoch = 4'd0;
    write_samples(10);
    do_trigger(4'b0001, 8'd8, 8'd3, 1'b1, st);
    write_samples(4);
    for (int i = 0; i < 8; i++)
      exp_q.push_back('{data: WIDTH'(7 + i), ch: '0, last: (i == 7)});
    read_n(8);
    finish_readout("basic");
    check("basic_trig_lost", trig_lost, 0);

    // Multi-channel masked readout: ch1 x2 then ch3 x2.
    epoch = 4'd1;
    do_trigger(4'b1010, 8'd2, 8'd1, 1'b1, st);
    push_words(4'b1010, st, 2);
    read_n(4);
    finish_readout("masked");

    // Offset clamped to howmany: readout starts immediately.
    epoch = 4'd2;
    write_samples(3);
    do_trigger(4'b0100, 8'd5, 8'd20, 1'b0, st);
    push_words(4'b0100, st, 5);
    read_n(5);
    finish_readout("clamp");

    // howmany=0: ro_done pulse without any data word.
    empty_done = 1;
    do_trigger(4'b0001, 8'd0, 8'd0, 1'b0, st);
    finish_readout("hm_zero");

    // Trigger during POST is ignored but flagged.
    epoch = 4'd3;
    do_trigger(4'b0001, 8'd4, 8'd1, 1'b0, st);
    write_samples(1);
    ch_mask = 4'b1111;
    howmany = 8'd2;
    TRIGGER = 1'b1;
    drive_and_record();
    DAVAIL = 1'b1;
    @(posedge CK50);
    #1;
    TRIGGER = 1'b0;
    DAVAIL = 1'b0;
    write_samples(1);
    check("lost_trig_flag", trig_lost, 1);
    check("lost_busy", busy, 1);
    push_words(4'b0001, st, 4);
    read_n(4);
    finish_readout("lost");

    // Reset in the middle of a readout aborts cleanly.
    epoch = 4'd4;
    do_trigger(4'b0001, 8'd6, 8'd6, 1'b0, st);
    for (int i = 0; i < 3; i++)
      exp_q.push_back('{data: model_mem[0][st + SIZE'(i)], ch: '0, last: 1'b0});
    read_n(3);
    @(negedge CK50);
    #1;
    check("midrst_partial", exp_q.size(), 0);
    RST = 1'b1;
    @(negedge CK50);
    check("midrst_dout_valid", dout_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_ro_done", ro_done, 0);
    check("midrst_trig_lost", trig_lost, 0);
    @(posedge CK50);
    #1;
    RST = 1'b0;
    tb_wp = '0;
    epoch = 4'd5;
    write_samples(3);
    do_trigger(4'b0011, 8'd3, 8'd2, 1'b1, st);
    push_words(4'b0011, st, 3);
    read_n(6);
    finish_readout("after_rst");

    // Wrap-around: trigger at wp=1, reads 253,254,255,0,1,2.
    do_reset();
    epoch = 4'd6;
    write_samples(257);
    do_trigger(4'b0001, 8'd6, 8'd4, 1'b1, st);
    write_samples(1);
    for (int i = 0; i < 6; i++) begin
      logic [SIZE-1:0] a;
      a = SIZE'(253 + i);
      exp_q.push_back('{data: {4'd6, 4'd0, a}, ch: '0, last: (i == 5)});
    end
    read_n(6);
    finish_readout("wrap");

    repeat (2) @(posedge CK50);
    $display("[TB] %0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
